// File: rtl/booth_defs.sv
// Shared constants and state encoding for the Booth multiplier datapath stages.
package booth_defs;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;
  localparam int OUT_W  = 32;
  localparam int LEN    = 16;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

endpackage

// File: rtl/sat_narrow.sv
// Signed saturating narrow from IN_W to OUT_W bits, with a flag when clipping occurred.
module sat_narrow #(
  parameter int IN_W  = 40,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             sat
);

  // Signed OUT_W limits sign-extended to IN_W for a direct signed compare.
  localparam logic [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [IN_W-1:0] MIN_V = ~MAX_V;

  always_comb begin
    dout = din[OUT_W-1:0];
    sat  = 1'b0;
    if ($signed(din) > $signed(MAX_V)) begin
      dout = {1'b0, {(OUT_W-1){1'b1}}};
      sat  = 1'b1;
    end else if ($signed(din) < $signed(MIN_V)) begin
      dout = {1'b1, {(OUT_W-1){1'b0}}};
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// Sums blocks of signed products in a guarded accumulator and presents the
// saturated block sum on a held result port.
module booth_product_accumulator
  import booth_defs::*;
#(
  parameter int PROD_W = booth_defs::PROD_W,
  parameter int ACC_W  = booth_defs::ACC_W,
  parameter int OUT_W  = booth_defs::OUT_W,
  parameter int LEN    = booth_defs::LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [OUT_W-1:0]  acc_data,
  output logic              acc_sat,
  output logic [7:0]        acc_count,
  output state_e            dbg_state
);

  // Handshakes: a beat moves on a rising edge where valid && ready. Valid never
  // waits on ready; once raised, valid and its payload hold until accepted.

  localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [OUT_W-1:0]   res_data_q, res_data_d;
  logic               res_sat_q, res_sat_d;
  logic [7:0]         res_count_q, res_count_d;

  logic [ACC_W-1:0]   sum;
  logic [OUT_W-1:0]   sat_data;
  logic               sat_flag;
  logic               xfer;
  logic               close;

  assign sum   = acc_q + {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
  assign xfer  = prod_valid && prod_ready;
  assign close = xfer && (prod_last || (cnt_q == LAST_CNT));

  sat_narrow #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .din  (sum),
    .dout (sat_data),
    .sat  (sat_flag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_sat_q   <= 1'b0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_sat_q   <= res_sat_d;
      res_count_q <= res_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_sat_d   = res_sat_q;
    res_count_d = res_count_q;
    unique case (state_q)
      ST_ACCUM: begin
        if (close) begin
          res_data_d  = sat_data;
          res_sat_d   = sat_flag;
          res_count_d = cnt_q + 8'd1;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = ST_HOLD;
        end else if (xfer) begin
          acc_d = sum;
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (acc_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // Both ready and valid come straight from the state register.
  assign prod_ready = (state_q == ST_ACCUM);
  assign acc_valid  = (state_q == ST_HOLD);
  assign acc_data   = res_data_q;
  assign acc_sat    = res_sat_q;
  assign acc_count  = res_count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator: directed literal cases plus randomized
// blocks checked every cycle against a plain-arithmetic block-sum model.
module tb_booth_product_accumulator;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;
  localparam int OUT_W  = 32;
  localparam int LEN    = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              prod_valid = 1'b0;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data = '0;
  logic              prod_last = 1'b0;
  logic              acc_valid;
  logic              acc_ready = 1'b0;
  logic [OUT_W-1:0]  acc_data;
  logic              acc_sat;
  logic [7:0]        acc_count;
  logic              dbg_state;

  int total = 0;
  int bad   = 0;
  logic rand_mode = 1'b0;

  // Expected results: {sat, count, data}
  logic [40:0] exp_q[$];
  longint m_sum = 0;
  int     m_cnt = 0;
  logic   m_hold = 1'b0;
  logic   m_after_rst = 1'b0;
  int     n_model_acc = 0;
  int     n_dut_acc = 0;

  booth_product_accumulator #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .LEN    (LEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_data  (prod_data),
    .prod_last  (prod_last),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data),
    .acc_sat    (acc_sat),
    .acc_count  (acc_count),
    .dbg_state  (dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // scoreboard / reference model, evaluated between edges
  always @(negedge clk) begin
    logic [40:0] e;
    if (m_after_rst) begin
      chk("rst_acc_data", 64'(acc_data), 64'd0);
      chk("rst_acc_sat", 64'(acc_sat), 64'd0);
      chk("rst_acc_count", 64'(acc_count), 64'd0);
    end
    chk("prod_ready", 64'(prod_ready), 64'(!m_hold));
    chk("acc_valid", 64'(acc_valid), 64'(m_hold));
    chk("dbg_state", 64'(dbg_state), 64'(m_hold));
    if (m_hold && acc_valid) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_nonempty", 64'd0, 64'd1);
      end else begin
        e = exp_q[0];
        chk("acc_data", 64'(acc_data), 64'(e[31:0]));
        chk("acc_count", 64'(acc_count), 64'(e[39:32]));
        chk("acc_sat", 64'(acc_sat), 64'(e[40]));
      end
    end
    if (acc_valid && acc_ready && !reset) n_dut_acc++;

    // advance the model to what the coming rising edge does
    if (reset) begin
      m_sum = 0;
      m_cnt = 0;
      m_hold = 1'b0;
      exp_q.delete();
      m_after_rst = 1'b1;
    end else begin
      m_after_rst = 1'b0;
      if (m_hold) begin
        if (acc_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_hold = 1'b0;
          n_model_acc++;
        end
      end else if (prod_valid) begin
        m_sum += longint'($signed(prod_data));
        m_cnt++;
        if (prod_last || m_cnt == LEN) begin
          if (m_sum > 64'sd2147483647)
            exp_q.push_back({1'b1, 8'(m_cnt), 32'h7FFF_FFFF});
          else if (m_sum < -64'sd2147483648)
            exp_q.push_back({1'b1, 8'(m_cnt), 32'h8000_0000});
          else
            exp_q.push_back({1'b0, 8'(m_cnt), m_sum[31:0]});
          m_sum = 0;
          m_cnt = 0;
          m_hold = 1'b1;
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) acc_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int guard;
    logic took;
    guard = 0;
    took = 1'b0;
    prod_valid = 1'b1;
    prod_data = d;
    prod_last = l;
    while (!took) begin
      @(negedge clk);
      took = prod_ready;
      step();
      guard++;
      if (!took && guard > 200) begin
        chk("send_timeout", 64'd1, 64'd0);
        took = 1'b1;
      end
    end
    prod_valid = 1'b0;
    prod_last = 1'b0;
  endtask

  // Result must already be valid in the cycle right after the closing transfer.
  task automatic check_result(input string name, input logic [31:0] d, input logic s,
                              input logic [7:0] c);
    @(negedge clk);
    chk({name, "_valid"}, 64'(acc_valid), 64'd1);
    chk({name, "_data"}, 64'(acc_data), 64'(d));
    chk({name, "_sat"}, 64'(acc_sat), 64'(s));
    chk({name, "_count"}, 64'(acc_count), 64'(c));
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
  endtask

  initial begin
    int cycles;
    int base;
    logic [31:0] d;

    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_valid", 64'(acc_valid), 64'd0);
    chk("reset_data", 64'(acc_data), 64'd0);
    chk("reset_count", 64'(acc_count), 64'd0);
    chk("reset_ready", 64'(prod_ready), 64'd1);
    step();

    // four small products
    send(32'd100, 1'b0);
    send(-32'sd30, 1'b0);
    send(32'd7, 1'b0);
    send(32'd3, 1'b1);
    check_result("t1", 32'd80, 1'b0, 8'd4);

    // positive saturation, closes on the LEN-th product
    for (int i = 0; i < LEN; i++) send(32'h7FFF_0001, 1'b0);
    check_result("t2", 32'h7FFF_FFFF, 1'b1, 8'd16);

    // negative saturation then a single negative product
    for (int i = 0; i < LEN; i++) send(32'h8000_0000, 1'b0);
    check_result("t3a", 32'h8000_0000, 1'b1, 8'd16);
    send(-32'sd5, 1'b1);
    check_result("t3b", 32'hFFFF_FFFB, 1'b0, 8'd1);

    // long hold with products offered
    send(32'd10, 1'b0);
    send(32'd20, 1'b1);
    prod_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      prod_data = $urandom;
      prod_last = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("t4_ready_low", 64'(prod_ready), 64'd0);
      chk("t4_hold_data", 64'(acc_data), 64'd30);
      chk("t4_hold_count", 64'(acc_count), 64'd2);
      step();
    end
    prod_valid = 1'b0;
    prod_last = 1'b0;
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    send(32'd9, 1'b1);
    check_result("t4", 32'd9, 1'b0, 8'd1);

    // reset in the middle of a block
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", 64'(acc_valid), 64'd0);
    chk("t5_rst_data", 64'(acc_data), 64'd0);
    chk("t5_rst_count", 64'(acc_count), 64'd0);
    step();
    send(32'd2, 1'b0);
    send(32'd2, 1'b1);
    check_result("t5", 32'd4, 1'b0, 8'd2);

    // randomized blocks
    rand_mode = 1'b1;
    base = n_model_acc;
    cycles = 0;
    while (n_model_acc < base + 1000 && cycles < 60000) begin
      if ($urandom_range(0, 1) == 0) begin
        step();
        cycles++;
      end
      if ($urandom_range(0, 3) == 0) d = $urandom;
      else d = 32'($urandom_range(0, 2000)) - 32'd1000;
      send(d, 1'($urandom_range(0, 7) == 0));
      cycles++;
    end
    chk("rand_blocks_done", 64'(n_model_acc >= base + 1000), 64'd1);
    rand_mode = 1'b0;
    acc_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    acc_ready = 1'b0;
    chk("drain_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("accept_count", 64'(n_dut_acc), 64'(n_model_acc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
